// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage. in_ready is a registered output, so the
// upstream ready path never sees downstream stall logic combinationally.
module pipe_skid_stage #(
    parameter int unsigned LENGTH       = 32,
    parameter bit          ZERO_INVALID = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e            state;
    logic [LENGTH-1:0] main_data;
    logic [LENGTH-1:0] skid_data;
    logic              acc;
    logic              pop;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // out_valid, in_ready and occupancy are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StEmpty;
            main_data <= '0;
            skid_data <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else if (flush) begin
            // A word accepted this cycle is dropped; data registers keep their contents.
            state     <= StEmpty;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (acc) begin
                        state     <= StBusy;
                        main_data <= in_data;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                StBusy: begin
                    if (acc && pop) begin
                        main_data <= in_data;
                    end else if (acc) begin
                        state     <= StFull;
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        occupancy <= 2'd2;
                    end else if (pop) begin
                        state     <= StEmpty;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                StFull: begin
                    // Skid drains into main before anything new can be accepted.
                    if (pop) begin
                        state     <= StBusy;
                        main_data <= skid_data;
                        in_ready  <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    state     <= StEmpty;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        out_data = main_data;
        if (ZERO_INVALID && !out_valid) begin
            out_data = '0;
        end
    end

endmodule
